// File: rtl/telemetry_pkg.sv
// telemetry_pkg: constants, state encodings, snapshot layout and checksum
// shared by the telemetry framer and its command parser.
package telemetry_pkg;

  localparam logic [7:0] SYNC_TX   = 8'hA5;
  localparam logic [7:0] SYNC_RX   = 8'h5A;
  localparam int         FRAME_LEN = 6;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_STROBE,
    TX_WAIT_BUSY,
    TX_WAIT_IDLE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_VALUE,
    RX_CHECK
  } rx_state_t;

  typedef struct packed {
    logic [7:0] heart_rate;
    logic [7:0] speed;
    logic [9:0] angle;
    logic [3:0] flags;
  } snapshot_t;

  // 8-bit wrapping sum of the four payload bytes
  function automatic logic [7:0] checksum(input logic [7:0] b1,
                                          input logic [7:0] b2,
                                          input logic [7:0] b3,
                                          input logic [7:0] b4);
    logic [7:0] sum;
    sum = b1 + b2 + b3 + b4;
    return sum;
  endfunction

endpackage

// File: rtl/telemetry_framer_cmd_parser.sv
// telemetry_cmd_parser: recognises 3-byte command frames {0x5A, v, ~v} and
// updates the heart-rate cap when v is acceptable.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   RX_HUNT  | waiting for the 0x5A sync byte
//   RX_VALUE | sync seen, next byte is the requested cap v
//   RX_CHECK | v latched, next byte must be ~v
module telemetry_cmd_parser
  import telemetry_pkg::*;
#(
  parameter int HEART_CAP_DEFAULT = 200,
  parameter int HEART_CAP_MIN     = 60,
  parameter int RX_TIMEOUT        = 500_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       received_i,
  input  logic [7:0] rx_byte_i,
  output logic [7:0] heart_cap_o,
  output logic       cap_update_o
);

  localparam int             GW       = $clog2(RX_TIMEOUT);
  localparam logic [GW-1:0]  GAP_LAST = GW'(RX_TIMEOUT - 1);
  localparam logic [7:0]     CAP_DEF  = 8'(HEART_CAP_DEFAULT);
  localparam logic [7:0]     CAP_MIN  = 8'(HEART_CAP_MIN);

  rx_state_t      state_q;
  logic [7:0]     value_q;
  logic [7:0]     cap_q;
  logic           upd_q;
  logic [GW-1:0]  gap_q;

  // Parser FSM; gap_q counts idle cycles since the last byte of a frame and
  // the frame is abandoned once more than RX_TIMEOUT cycles separate strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RX_HUNT;
      value_q <= '0;
      cap_q   <= CAP_DEF;
      upd_q   <= 1'b0;
      gap_q   <= '0;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        RX_HUNT: begin
          gap_q <= '0;
          if (received_i && rx_byte_i == SYNC_RX) state_q <= RX_VALUE;
        end
        RX_VALUE: begin
          if (received_i) begin
            value_q <= rx_byte_i;
            gap_q   <= '0;
            state_q <= RX_CHECK;
          end else if (gap_q == GAP_LAST) begin
            state_q <= RX_HUNT;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        RX_CHECK: begin
          if (received_i) begin
            gap_q <= '0;
            if (rx_byte_i == ~value_q) begin
              state_q <= RX_HUNT;
              if (value_q >= CAP_MIN && value_q != cap_q) begin
                cap_q <= value_q;
                upd_q <= 1'b1;
              end
            end else if (rx_byte_i == SYNC_RX) begin
              // A failed check byte that looks like sync starts a new frame
              state_q <= RX_VALUE;
            end else begin
              state_q <= RX_HUNT;
            end
          end else if (gap_q == GAP_LAST) begin
            state_q <= RX_HUNT;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= RX_HUNT;
      endcase
    end
  end

  assign heart_cap_o  = cap_q;
  assign cap_update_o = upd_q;

endmodule

// File: rtl/telemetry_framer.sv
// telemetry_framer: every PERIOD_CYCLES snapshots the ride sensors and sends a
// 6-byte frame {A5, hr, speed, flags|angle_hi, angle_lo, checksum} through the
// UART transmit handshake. Build option TELEMETRY_RX_CMD_EN adds the command
// parser that lets the host rewrite heart_cap; without it heart_cap is fixed.
//
//   state        | meaning
//   -------------+-------------------------------------------------
//   TX_IDLE      | no frame in progress, waiting for the period tick
//   TX_LOAD      | present byte idx on tx_byte, wait for UART idle
//   TX_STROBE    | transmit high for this single cycle
//   TX_WAIT_BUSY | wait (max 4 cycles) for the UART to report busy
//   TX_WAIT_IDLE | wait for the UART to finish, then next byte
module telemetry_framer
  import telemetry_pkg::*;
#(
  parameter int PERIOD_CYCLES     = 5_000_000,
  parameter int HEART_CAP_DEFAULT = 200,
  parameter int HEART_CAP_MIN     = 60,
  parameter int RX_TIMEOUT        = 500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] heart_rate,
  input  logic [7:0] speed,
  input  logic [9:0] resolved_angle,
  input  logic [3:0] flags,
  output logic       transmit,
  output logic [7:0] tx_byte,
  input  logic       is_transmitting,
  input  logic       received,
  input  logic [7:0] rx_byte,
  output logic [7:0] heart_cap,
  output logic       cap_update,
  output logic       frame_overrun
);

  localparam int            PW          = $clog2(PERIOD_CYCLES);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX    = 3'(FRAME_LEN - 1);
  localparam logic [1:0]    BUSY_LAST   = 2'd3;

  logic [PW-1:0] period_q, period_d;
  logic          tick;

  tx_state_t     state_q;
  logic [2:0]    idx_q;
  logic [1:0]    busy_cnt_q;
  snapshot_t     snap_q;
  logic [7:0]    tx_byte_q;
  logic          transmit_q;
  logic          overrun_q;
  logic [7:0]    byte_sel;

  // Free-running frame period: 0 .. PERIOD_CYCLES-1, tick on the wrap value
  always_comb begin
    tick     = (period_q == PERIOD_LAST);
    period_d = tick ? '0 : period_q + 1'b1;
  end

  // Period counter register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) period_q <= '0;
    else       period_q <= period_d;
  end

  // Frame byte for the current index, built from the captured snapshot
  always_comb begin
    case (idx_q)
      3'd0:    byte_sel = SYNC_TX;
      3'd1:    byte_sel = snap_q.heart_rate;
      3'd2:    byte_sel = snap_q.speed;
      3'd3:    byte_sel = {snap_q.flags, 2'b00, snap_q.angle[9:8]};
      3'd4:    byte_sel = snap_q.angle[7:0];
      default: byte_sel = checksum(snap_q.heart_rate, snap_q.speed,
                                   {snap_q.flags, 2'b00, snap_q.angle[9:8]},
                                   snap_q.angle[7:0]);
    endcase
  end

  // TX FSM with registered transmit/tx_byte/overrun outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      idx_q      <= '0;
      busy_cnt_q <= '0;
      snap_q     <= '0;
      tx_byte_q  <= '0;
      transmit_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      transmit_q <= 1'b0;
      overrun_q  <= tick && (state_q != TX_IDLE);
      case (state_q)
        TX_IDLE: begin
          if (tick) begin
            snap_q  <= '{heart_rate: heart_rate, speed: speed,
                         angle: resolved_angle, flags: flags};
            idx_q   <= '0;
            state_q <= TX_LOAD;
          end
        end
        TX_LOAD: begin
          tx_byte_q <= byte_sel;
          if (!is_transmitting) begin
            transmit_q <= 1'b1;
            state_q    <= TX_STROBE;
          end
        end
        TX_STROBE: begin
          busy_cnt_q <= '0;
          state_q    <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: begin
          if (is_transmitting) begin
            state_q <= TX_WAIT_IDLE;
          end else if (busy_cnt_q == BUSY_LAST) begin
            // UART never acknowledged: treat the byte as sent
            if (idx_q == LAST_IDX) begin
              state_q <= TX_IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= TX_LOAD;
            end
          end else begin
            busy_cnt_q <= busy_cnt_q + 1'b1;
          end
        end
        TX_WAIT_IDLE: begin
          if (!is_transmitting) begin
            if (idx_q == LAST_IDX) begin
              state_q <= TX_IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= TX_LOAD;
            end
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign transmit      = transmit_q;
  assign tx_byte       = tx_byte_q;
  assign frame_overrun = overrun_q;

`ifdef TELEMETRY_RX_CMD_EN
  telemetry_cmd_parser #(
    .HEART_CAP_DEFAULT (HEART_CAP_DEFAULT),
    .HEART_CAP_MIN     (HEART_CAP_MIN),
    .RX_TIMEOUT        (RX_TIMEOUT)
  ) u_cmd_parser (
    .clk_i        (CLOCK_50),
    .rst_i        (reset),
    .received_i   (received),
    .rx_byte_i    (rx_byte),
    .heart_cap_o  (heart_cap),
    .cap_update_o (cap_update)
  );
`else
  logic unused_rx;
  assign unused_rx  = ^{received, rx_byte, 32'(HEART_CAP_MIN), 32'(RX_TIMEOUT)};
  assign heart_cap  = 8'(HEART_CAP_DEFAULT);
  assign cap_update = 1'b0;
`endif

endmodule
